// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start, DATA_WIDTH data bits LSB-first, optional parity, 1/2 stop bits.
// Latency: start bit appears on TX_OUT the cycle after the TX_VALID/TX_READY accept edge; all outputs registered.
// Backpressure: TX_READY is high only in IDLE; a word is consumed solely on the handshake edge.
// Optional feature: define UART_TX_BREAK_EN to add the BREAK_REQ input and the line-break state.
module uart_tx_frame_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [DATA_WIDTH-1:0] TX_DATA,
   input  logic                  TX_VALID,
   output logic                  TX_READY,
   input  logic [31:0]           PARITY_TYPE,
   input  logic                  STOP_BITS,
   output logic [DATA_WIDTH-1:0] PAR_DATA,
   output logic [31:0]           PAR_TYPE,
   input  logic                  PAR_BIT,
   output logic                  TX_OUT,
   output logic                  BUSY
`ifdef UART_TX_BREAK_EN
   ,
   input  logic                  BREAK_REQ
`endif
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
`ifdef UART_TX_BREAK_EN
      ,
      S_BREAK
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [31:0]           ptype_q, ptype_d;
   logic                  stop2_q, stop2_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  bit_end;
   logic                  par_en;

`ifdef UART_TX_BREAK_EN
   // Minimum break length; the line stays low longer while BREAK_REQ remains asserted.
   localparam int BRK_CYC = (DATA_WIDTH + 3) * CLKS_PER_BIT;
   localparam int BW      = $clog2(BRK_CYC);
   logic [BW-1:0]         brk_cnt_q, brk_cnt_d;
`endif

   assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
   assign par_en  = (ptype_q >= 32'd1) && (ptype_q <= 32'd4);

   assign TX_OUT   = tx_q;
   assign TX_READY = ready_q;
   assign BUSY     = busy_q;
   assign PAR_DATA = data_q;
   assign PAR_TYPE = ptype_q;

   // Next-state, counter and registered-output logic; outputs are derived from the next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      idx_d   = idx_q;
      data_d  = data_q;
      ptype_d = ptype_q;
      stop2_d = stop2_q;
      par_d   = par_q;
`ifdef UART_TX_BREAK_EN
      brk_cnt_d = brk_cnt_q;
`endif

      if (state_q != S_IDLE && !bit_end) begin
         cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            idx_d = '0;
`ifdef UART_TX_BREAK_EN
            if (BREAK_REQ) begin
               state_d   = S_BREAK;
               stop2_d   = 1'b0;
               brk_cnt_d = '0;
            end else
`endif
            if (TX_VALID && ready_q) begin
               data_d  = TX_DATA;
               ptype_d = PARITY_TYPE;
               stop2_d = STOP_BITS;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == IW'(DATA_WIDTH - 1)) begin
                  idx_d = '0;
                  if (par_en) begin
                     // Data has been stable since accept, so the generator output is settled here.
                     state_d = S_PARITY;
                     par_d   = PAR_BIT;
                  end else begin
                     state_d = S_STOP;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               idx_d   = '0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               // idx doubles as the stop-bit counter for the two-stop-bit case.
               if (stop2_q && idx_q == '0) begin
                  idx_d = IW'(1);
               end else begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            cnt_d = '0;
            if (brk_cnt_q != BW'(BRK_CYC - 1)) begin
               brk_cnt_d = brk_cnt_q + 1'b1;
            end else if (!BREAK_REQ) begin
               state_d = S_STOP;
               idx_d   = '0;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[idx_d];
         S_PARITY: tx_d = par_d;
`ifdef UART_TX_BREAK_EN
         S_BREAK:  tx_d = 1'b0;
`endif
         default:  tx_d = 1'b1;
      endcase

      ready_d = (state_d == S_IDLE);
      busy_d  = ~ready_d;
   end

   // State, counters, latched frame parameters and registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         ptype_q <= '0;
         stop2_q <= 1'b0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         ptype_q <= ptype_d;
         stop2_q <= stop2_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

`ifdef UART_TX_BREAK_EN
   // Break duration counter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         brk_cnt_q <= '0;
      end else begin
         brk_cnt_q <= brk_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: directed and random frames against a bit-list reference model.
module tb_uart_tx_frame_ctrl;

   localparam int DW  = 8;
   localparam int CPB = 4;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b1;
   logic [DW-1:0] TX_DATA = '0;
   logic          TX_VALID = 1'b0;
   logic          TX_READY;
   logic [31:0]   PARITY_TYPE = '0;
   logic          STOP_BITS = 1'b0;
   logic [DW-1:0] PAR_DATA;
   logic [31:0]   PAR_TYPE;
   logic          PAR_BIT;
   logic          TX_OUT;
   logic          BUSY;
`ifdef UART_TX_BREAK_EN
   logic          BREAK_REQ = 1'b0;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   uart_tx_frame_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .TX_DATA(TX_DATA),
      .TX_VALID(TX_VALID),
      .TX_READY(TX_READY),
      .PARITY_TYPE(PARITY_TYPE),
      .STOP_BITS(STOP_BITS),
      .PAR_DATA(PAR_DATA),
      .PAR_TYPE(PAR_TYPE),
      .PAR_BIT(PAR_BIT),
      .TX_OUT(TX_OUT),
      .BUSY(BUSY)
`ifdef UART_TX_BREAK_EN
      ,
      .BREAK_REQ(BREAK_REQ)
`endif
   );

   // Parity rule: 1 even, 2 odd, 3 mark, 4 space, anything else none.
   function automatic logic par_model(input logic [DW-1:0] d, input logic [31:0] p);
      case (p)
         32'd1:   return ^d;
         32'd2:   return ~(^d);
         32'd3:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit has_par(input logic [31:0] p);
      return (p >= 32'd1) && (p <= 32'd4);
   endfunction

   // External parity generator fed from the latched word and type.
   assign PAR_BIT = par_model(PAR_DATA, PAR_TYPE);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [DW-1:0] d, input logic [31:0] p, input logic s);
      TX_DATA     = d;
      PARITY_TYPE = p;
      STOP_BITS   = s;
   endtask

   // Wait (bounded) for TX_READY at a falling edge, then present a word.
   task automatic start(input logic [DW-1:0] d, input logic [31:0] p, input logic s);
      int waited = 0;
      @(negedge CLK);
      while (TX_READY !== 1'b1 && waited < 200) begin
         @(negedge CLK);
         waited++;
      end
      chk("ready_wait", 32'(TX_READY), 32'd1);
      load_word(d, p, s);
      TX_VALID = 1'b1;
   endtask

   // Check one frame from its first cycle, then the single idle cycle after it.
   task automatic run_frame(input logic [DW-1:0] d, input logic [31:0] p, input logic s,
                            input logic chain, input logic [DW-1:0] nd,
                            input logic [31:0] np, input logic ns);
      logic q[$];
      int   busy_cnt = 0;
      int   exp_len;
      bit   ok;
      q.push_back(1'b0);
      for (int i = 0; i < DW; i++) q.push_back(d[i]);
      if (has_par(p)) q.push_back(par_model(d, p));
      q.push_back(1'b1);
      if (s) q.push_back(1'b1);
      exp_len = CPB * (1 + DW + (has_par(p) ? 1 : 0) + (s ? 2 : 1));

      for (int b = 0; b < q.size(); b++) begin
         ok = 1'b1;
         for (int c = 0; c < CPB; c++) begin
            @(negedge CLK);
            if (TX_OUT !== q[b]) ok = 1'b0;
            if (BUSY === 1'b1 && TX_READY === 1'b0) busy_cnt++;
            if (b == 0 && c == 0) begin
               chk("par_data", 32'(PAR_DATA), 32'(d));
               chk("par_type", PAR_TYPE, p);
               if (chain) begin
                  load_word(nd, np, ns);
               end else begin
                  TX_VALID = 1'b0;
                  load_word(DW'($urandom), $urandom, 1'($urandom_range(0, 1)));
               end
            end
         end
         chk($sformatf("line_d%0h_p%0d_bit%0d", d, p, b), 32'(ok), 32'd1);
      end
      chk("busy_len", 32'(busy_cnt), 32'(exp_len));
      @(negedge CLK);
      chk("idle_tx", 32'(TX_OUT), 32'd1);
      chk("idle_rdy", 32'(TX_READY), 32'd1);
      chk("idle_busy", 32'(BUSY), 32'd0);
   endtask

   logic [DW-1:0] rd [0:8];
   logic [31:0]   rp [0:8];
   logic          rs [0:8];

   initial begin
      bit ok;
      bit ch;

      // Reset behaviour.
      #3 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_tx", 32'(TX_OUT), 32'd1);
      chk("rst_rdy", 32'(TX_READY), 32'd1);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_pdata", 32'(PAR_DATA), 32'd0);
      chk("rst_ptype", PAR_TYPE, 32'd0);
      RST_N = 1'b1;

      // Idle with no stimulus.
      ok = 1'b1;
      repeat (20) begin
         @(negedge CLK);
         if (TX_OUT !== 1'b1 || TX_READY !== 1'b1 || BUSY !== 1'b0) ok = 1'b0;
      end
      chk("idle_quiet", 32'(ok), 32'd1);

      // 0xA5 across every parity flavour plus an out-of-range type.
      start(8'hA5, 32'd1, 1'b0); run_frame(8'hA5, 32'd1, 1'b0, 1'b0, '0, '0, 1'b0);
      start(8'hA5, 32'd2, 1'b0); run_frame(8'hA5, 32'd2, 1'b0, 1'b0, '0, '0, 1'b0);
      start(8'hA5, 32'd3, 1'b0); run_frame(8'hA5, 32'd3, 1'b0, 1'b0, '0, '0, 1'b0);
      start(8'hA5, 32'd4, 1'b0); run_frame(8'hA5, 32'd4, 1'b0, 1'b0, '0, '0, 1'b0);
      start(8'hA5, 32'd7, 1'b0); run_frame(8'hA5, 32'd7, 1'b0, 1'b0, '0, '0, 1'b0);

      // Two stop bits, back-to-back with a second queued word.
      start(8'h00, 32'd0, 1'b1);
      run_frame(8'h00, 32'd0, 1'b1, 1'b1, 8'hC3, 32'd2, 1'b1);
      run_frame(8'hC3, 32'd2, 1'b1, 1'b0, '0, '0, 1'b0);

      // Random frames, randomly chained.
      for (int i = 0; i < 9; i++) begin
         rd[i] = DW'($urandom);
         rp[i] = $urandom_range(0, 7);
         rs[i] = 1'($urandom_range(0, 1));
      end
      start(rd[0], rp[0], rs[0]);
      for (int i = 0; i < 8; i++) begin
         ch = (i < 7) && ($urandom_range(0, 1) == 1);
         run_frame(rd[i], rp[i], rs[i], ch, rd[i+1], rp[i+1], rs[i+1]);
         if (!ch && i < 7) start(rd[i+1], rp[i+1], rs[i+1]);
      end

      // Reset in the middle of data bit 3 (a zero bit of 0xF0).
      start(8'hF0, 32'd0, 1'b0);
      repeat (CPB * 4 + 2) begin
         @(negedge CLK);
         TX_VALID = 1'b0;
      end
      chk("pre_rst_bit3", 32'(TX_OUT), 32'd0);
      #2 RST_N = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(TX_OUT), 32'd1);
      chk("mid_rst_rdy", 32'(TX_READY), 32'd1);
      chk("mid_rst_busy", 32'(BUSY), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      rp[0] = $urandom_range(0, 7);
      rs[0] = 1'($urandom_range(0, 1));
      start(8'h3C, rp[0], rs[0]);
      run_frame(8'h3C, rp[0], rs[0], 1'b0, '0, '0, 1'b0);

`ifdef UART_TX_BREAK_EN
      // Break held for 100 cycles, then one stop bit time.
      BREAK_REQ = 1'b1;
      ok = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge CLK);
         if (TX_OUT !== 1'b0 || BUSY !== 1'b1 || TX_READY !== 1'b0) ok = 1'b0;
         if (i == 100) BREAK_REQ = 1'b0;
      end
      chk("break_low", 32'(ok), 32'd1);
      ok = 1'b1;
      repeat (CPB) begin
         @(negedge CLK);
         if (TX_OUT !== 1'b1 || BUSY !== 1'b1) ok = 1'b0;
      end
      chk("break_stop", 32'(ok), 32'd1);
      @(negedge CLK);
      chk("break_rdy", 32'(TX_READY), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
